// File: rtl/axon_expand.sv
// Axon-side request generator: expands one accepted spike over a KSxKS kernel
// into a registered stream of synaptic update requests for sd, one position per cycle.
module axon_expand #(
    parameter int NNW     = 12,
    parameter int WD      = 6,
    parameter int CW      = 6,
    parameter int LAN_num = 2,
    parameter int CNTW    = 16
) (
    input  logic               clk_AXON,
    input  logic               rst,
    input  logic               tik,
    input  logic [CW-1:0]      spk_x,
    input  logic [CW-1:0]      spk_y,
    input  logic [LAN_num-1:0] spk_lans,
    input  logic               spk_vld,
    output logic               spk_rdy,
    input  logic [CW-1:0]      cfg_map_w,
    input  logic [CW-1:0]      cfg_map_h,
    input  logic [3:0]         cfg_ks,
    output logic [NNW-1:0]     axon_sd_vm_addr,
    output logic [WD-1:0]      axon_sd_wgt_addr,
    output logic [LAN_num-1:0] axon_sd_lans,
    output logic               axon_sd_vld,
    output logic               axon_busy,
    output logic [CNTW-1:0]    spk_cnt
);

    localparam int SW = (2*CW+1 > NNW) ? 2*CW+1 : NNW;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXPAND = 2'd1, S_GAP = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      x_q, y_q, mw_q, mh_q;
    logic [LAN_num-1:0] lans_q, lans_out_q;
    logic [3:0]         ks_q, kx_q, ky_q;
    logic               vld_q;
    logic [NNW-1:0]     vm_q;
    logic [WD-1:0]      wgt_q;
    logic [CNTW-1:0]    cnt_q;

    logic               accept_s, last_s, emit_s, in_range_s;
    logic [3:0]         ks_eff_s, pkx_s, pky_s;
    logic [CW-1:0]      px_s, py_s, pw_s, ph_s;
    logic [LAN_num-1:0] plans_s;
    logic signed [CW:0] tx_s, ty_s;
    logic [SW-1:0]      sum_s;

    // Kernel side clamp and end-of-kernel detection
    always_comb begin
        if (cfg_ks > 4'd8) begin
            ks_eff_s = 4'd8;
        end else begin
            ks_eff_s = cfg_ks;
        end
        last_s   = (kx_q == ks_q - 4'd1) && (ky_q == ks_q - 4'd1);
        accept_s = spk_vld && spk_rdy;
    end

    // State register
    always_ff @(posedge clk_AXON) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = (ks_eff_s == 4'd0) ? S_GAP : S_EXPAND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXPAND: state_d = last_s ? S_GAP : S_EXPAND;
            S_GAP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        spk_rdy   = (state_q == S_IDLE) && !tik && !rst;
        axon_busy = (state_q == S_EXPAND) || (state_q == S_GAP);
    end

    // Position to present next cycle: (0,0) of the incoming spike at accept,
    // otherwise the successor of the position currently on the outputs
    always_comb begin
        px_s    = x_q;
        py_s    = y_q;
        pw_s    = mw_q;
        ph_s    = mh_q;
        plans_s = lans_q;
        pkx_s   = kx_q;
        pky_s   = ky_q;
        emit_s  = 1'b0;
        if (state_q == S_IDLE) begin
            px_s    = spk_x;
            py_s    = spk_y;
            pw_s    = cfg_map_w;
            ph_s    = cfg_map_h;
            plans_s = spk_lans;
            pkx_s   = 4'd0;
            pky_s   = 4'd0;
            emit_s  = accept_s && (ks_eff_s != 4'd0);
        end else begin
            if (kx_q == ks_q - 4'd1) begin
                pkx_s = 4'd0;
                pky_s = ky_q + 4'd1;
            end else begin
                pkx_s = kx_q + 4'd1;
                pky_s = ky_q;
            end
            emit_s = (state_q == S_EXPAND) && !last_s;
        end
    end

    assign tx_s = $signed({1'b0, px_s}) - $signed({{(CW-3){1'b0}}, pkx_s});
    assign ty_s = $signed({1'b0, py_s}) - $signed({{(CW-3){1'b0}}, pky_s});
    assign in_range_s = !tx_s[CW] && !ty_s[CW] && (tx_s[CW-1:0] < pw_s) && (ty_s[CW-1:0] < ph_s);
    assign sum_s = SW'(ty_s[CW-1:0]) * SW'(pw_s) + SW'(tx_s[CW-1:0]);

    // Spike latch, kernel counters, registered request outputs and spike counter
    always_ff @(posedge clk_AXON) begin
        if (rst) begin
            x_q        <= {CW{1'b0}};
            y_q        <= {CW{1'b0}};
            mw_q       <= {CW{1'b0}};
            mh_q       <= {CW{1'b0}};
            lans_q     <= {LAN_num{1'b0}};
            ks_q       <= 4'd0;
            kx_q       <= 4'd0;
            ky_q       <= 4'd0;
            vld_q      <= 1'b0;
            vm_q       <= {NNW{1'b0}};
            wgt_q      <= {WD{1'b0}};
            lans_out_q <= {LAN_num{1'b0}};
            cnt_q      <= {CNTW{1'b0}};
        end else begin
            if (accept_s) begin
                x_q    <= spk_x;
                y_q    <= spk_y;
                mw_q   <= cfg_map_w;
                mh_q   <= cfg_map_h;
                lans_q <= spk_lans;
                ks_q   <= ks_eff_s;
            end
            if (emit_s) begin
                kx_q  <= pkx_s;
                ky_q  <= pky_s;
                vld_q <= in_range_s;
                // Out-of-range positions consume the cycle but leave the address bus untouched
                if (in_range_s) begin
                    vm_q       <= sum_s[NNW-1:0];
                    wgt_q      <= WD'({pky_s[2:0], pkx_s[2:0]});
                    lans_out_q <= plans_s;
                end
            end else begin
                vld_q <= 1'b0;
            end
            if (tik) begin
                cnt_q <= {CNTW{1'b0}};
            end else if (accept_s && (cnt_q != {CNTW{1'b1}})) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    assign axon_sd_vld      = vld_q;
    assign axon_sd_vm_addr  = vm_q;
    assign axon_sd_wgt_addr = wgt_q;
    assign axon_sd_lans     = lans_out_q;
    assign spk_cnt          = cnt_q;

endmodule

// File: tb/tb_axon_expand.sv
// Randomized self-checking bench for axon_expand; expected requests come from
// integer kernel arithmetic over each spike, with a per-address spacing check.
module tb_axon_expand;

    logic        clk_AXON = 1'b0;
    logic        rst, tik;
    logic [5:0]  spk_x, spk_y, cfg_map_w, cfg_map_h;
    logic [1:0]  spk_lans;
    logic        spk_vld, spk_rdy;
    logic [3:0]  cfg_ks;
    logic [11:0] axon_sd_vm_addr;
    logic [5:0]  axon_sd_wgt_addr;
    logic [1:0]  axon_sd_lans;
    logic        axon_sd_vld, axon_busy;
    logic [15:0] spk_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mcnt     = 0;
    int m_vm     = 0;
    int m_wgt    = 0;
    int last_seen [4096];

    axon_expand dut (
        .clk_AXON(clk_AXON), .rst(rst), .tik(tik),
        .spk_x(spk_x), .spk_y(spk_y), .spk_lans(spk_lans),
        .spk_vld(spk_vld), .spk_rdy(spk_rdy),
        .cfg_map_w(cfg_map_w), .cfg_map_h(cfg_map_h), .cfg_ks(cfg_ks),
        .axon_sd_vm_addr(axon_sd_vm_addr), .axon_sd_wgt_addr(axon_sd_wgt_addr),
        .axon_sd_lans(axon_sd_lans), .axon_sd_vld(axon_sd_vld),
        .axon_busy(axon_busy), .spk_cnt(spk_cnt)
    );

    always #5 clk_AXON = ~clk_AXON;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock; model counter and address hold follow the same edge
    task automatic step(input bit acc);
        if (rst) begin
            mcnt = 0; m_vm = 0; m_wgt = 0;
        end else if (tik) begin
            mcnt = 0;
        end else if (acc && mcnt != 65535) begin
            mcnt++;
        end
        @(posedge clk_AXON);
        #1;
        cyc++;
    endtask

    task automatic scramble_inputs();
        spk_x     = 6'($urandom);
        spk_y     = 6'($urandom);
        spk_lans  = 2'($urandom);
        cfg_map_w = 6'($urandom);
        cfg_map_h = 6'($urandom);
        cfg_ks    = 4'($urandom);
    endtask

    task automatic run_spike(input int x, input int y, input int lans, input int w,
                             input int h, input int ks, input int tik_at);
        int kse, kx, ky, tx, ty, a;
        bit inr;
        kse = (ks > 8) ? 8 : ks;
        spk_x = 6'(x); spk_y = 6'(y); spk_lans = 2'(lans);
        cfg_map_w = 6'(w); cfg_map_h = 6'(h); cfg_ks = 4'(ks);
        spk_vld = 1'b1;
        #1;
        check_eq("rdy_accept", 32'(spk_rdy), 1);
        step(1'b1);
        spk_vld = 1'b0;
        scramble_inputs();
        for (int i = 0; i < kse * kse; i++) begin
            kx = i % kse; ky = i / kse;
            tx = x - kx;  ty = y - ky;
            inr = (tx >= 0) && (tx < w) && (ty >= 0) && (ty < h);
            if (inr) begin
                m_vm  = (ty * w + tx) % 4096;
                m_wgt = ky * 8 + kx;
            end
            tik = (i == tik_at);
            #1;
            check_eq("vld", 32'(axon_sd_vld), 32'(inr));
            check_eq("vm_addr", 32'(axon_sd_vm_addr), m_vm);
            check_eq("wgt_addr", 32'(axon_sd_wgt_addr), m_wgt);
            if (inr) begin
                check_eq("lans", 32'(axon_sd_lans), lans);
                a = m_vm;
                check_eq("addr_spacing_ok", 32'((cyc - last_seen[a]) >= 2), 1);
                last_seen[a] = cyc;
            end
            check_eq("busy_exp", 32'(axon_busy), 1);
            check_eq("rdy_exp", 32'(spk_rdy), 0);
            check_eq("cnt_exp", 32'(spk_cnt), mcnt);
            step(1'b0);
            tik = 1'b0;
        end
        check_eq("vld_gap", 32'(axon_sd_vld), 0);
        check_eq("busy_gap", 32'(axon_busy), 1);
        check_eq("rdy_gap", 32'(spk_rdy), 0);
        check_eq("cnt_gap", 32'(spk_cnt), mcnt);
        step(1'b0);
        check_eq("busy_idle", 32'(axon_busy), 0);
        check_eq("rdy_idle", 32'(spk_rdy), 1);
        check_eq("vld_idle", 32'(axon_sd_vld), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) last_seen[i] = -100;
        rst = 1'b1; tik = 1'b0; spk_vld = 1'b0;
        scramble_inputs();
        #1;
        check_eq("rdy_in_reset", 32'(spk_rdy), 0);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        #1;
        check_eq("rst_vld", 32'(axon_sd_vld), 0);
        check_eq("rst_vm", 32'(axon_sd_vm_addr), 0);
        check_eq("rst_wgt", 32'(axon_sd_wgt_addr), 0);
        check_eq("rst_lans", 32'(axon_sd_lans), 0);
        check_eq("rst_busy", 32'(axon_busy), 0);
        check_eq("rst_cnt", 32'(spk_cnt), 0);
        check_eq("rst_rdy_after", 32'(spk_rdy), 1);

        // Directed kernel cases, including clipped corner, empty kernel and clamped kernel
        run_spike(5, 5, 1, 8, 8, 3, -1);
        run_spike(0, 1, 2, 8, 8, 3, -1);
        run_spike(3, 3, 3, 8, 8, 0, -1);
        check_eq("cnt_after_ks0", 32'(spk_cnt), 3);
        run_spike(10, 10, 1, 20, 20, 12, -1);
        run_spike(4, 4, 1, 0, 8, 3, -1);

        // tik held in IDLE blocks acceptance and clears the counter
        tik = 1'b1; spk_vld = 1'b1;
        #1;
        check_eq("rdy_tik_idle", 32'(spk_rdy), 0);
        step(1'b0);
        tik = 1'b0; spk_vld = 1'b0;
        #1;
        check_eq("busy_tik_idle", 32'(axon_busy), 0);
        check_eq("cnt_tik_idle", 32'(spk_cnt), 0);

        // tik mid-expansion: expansion unchanged, counter cleared
        run_spike(6, 2, 2, 10, 10, 4, 5);
        check_eq("cnt_after_mid_tik", 32'(spk_cnt), 0);

        // rst asserted in the 4th EXPAND cycle discards the spike
        spk_x = 6'd5; spk_y = 6'd5; spk_lans = 2'd1;
        cfg_map_w = 6'd8; cfg_map_h = 6'd8; cfg_ks = 4'd3; spk_vld = 1'b1;
        #1;
        step(1'b1);
        spk_vld = 1'b0;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        rst = 1'b1;
        #1;
        check_eq("rdy_rst_exp", 32'(spk_rdy), 0);
        step(1'b0);
        check_eq("vld_post_rst", 32'(axon_sd_vld), 0);
        check_eq("busy_post_rst", 32'(axon_busy), 0);
        check_eq("cnt_post_rst", 32'(spk_cnt), 0);
        check_eq("rdy_post_rst", 32'(spk_rdy), 0);
        check_eq("vm_post_rst", 32'(axon_sd_vm_addr), 0);
        rst = 1'b0;
        #1;
        check_eq("rdy_release", 32'(spk_rdy), 1);

        // Back-to-back spikes at one coordinate stress per-address spacing
        for (int i = 0; i < 6; i++) run_spike(3, 3, 1, 8, 8, 1 + (i % 2), -1);

        // Randomized spikes
        for (int n = 0; n < 30; n++) begin
            int w, h;
            w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            h = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            run_spike($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 3),
                      w, h, $urandom_range(0, 15),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1);
            check_eq("cnt_rand", 32'(spk_cnt), mcnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
